gate3_bist_ctrl: RTL and testbench

Self-test sequencer for any 3-input combinational gate (XOR, AND, OR, ...). On `start` it drives the gate's `a`, `b`, `c` inputs through all 8 combinations, holding each for a programmable number of cycles. It samples the gate output at the end of each hold and packs the samples into an 8-bit signature. It then compares the signature against the expected truth table and reports pass/fail. It sits between a test-control register block and the gate under test, replacing hand-written stimulus sequences in silicon and in simulation.

---
 rtl/gate3_bist_pkg.sv | 20 ++
 rtl/gate3_hold_timer.sv | 35 +++
 rtl/gate3_bist_ctrl.sv | 148 ++++++++++++++
 tb/tb_gate3_bist_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gate3_bist_pkg.sv
// Shared types and constants for the 3-input gate self-test sequencer.
package gate3_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;

  // Truth tables: bit k is the gate output for {a,b,c} = k.
  localparam logic [7:0] TT_XOR3  = 8'h96;
  localparam logic [7:0] TT_AND3  = 8'h80;
  localparam logic [7:0] TT_OR3   = 8'hFE;
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_XNOR3 = 8'h69;

endpackage

// File: rtl/gate3_hold_timer.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled and flags the last cycle.
module gate3_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/gate3_bist_ctrl.sv
// Self-test sequencer: walks a 3-input gate through all 8 vectors, captures
// its output into a signature and compares against the expected truth table.
module gate3_bist_ctrl
  import gate3_bist_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [7:0] EXPECTED    = 8'h96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] fail_mask,
  output state_e     dbg_state
);

  // Handshake: start is a request taken only when the sequencer is free (IDLE,
  // or the CHECK cycle for back-to-back runs); done is a one-cycle completion
  // strobe that qualifies pass/fail_mask, which then hold until the next start.

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] sig_q, sig_d;
  logic [7:0] fail_mask_q, fail_mask_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       clr_pend_q, clr_pend_d;
  logic       expire;

  gate3_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    ((state_q != RUN) || abort),
    .en     (state_q == RUN),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    sig_d       = sig_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    done_d      = 1'b0;
    clr_pend_d  = 1'b0;

    // A restart taken in CHECK keeps the verdict visible alongside done,
    // then clears the result registers one edge later.
    if (clr_pend_q) begin
      pass_d      = 1'b0;
      fail_mask_d = 8'd0;
      sig_d       = 8'd0;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = RUN;
          vec_d       = 3'd0;
          sig_d       = 8'd0;
          pass_d      = 1'b0;
          fail_mask_d = 8'd0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          vec_d       = 3'd0;
          pass_d      = 1'b0;
          fail_mask_d = 8'd0;
        end else if (expire) begin
          sig_d[vec_q] = f_in;
          if (vec_q == 3'(NUM_VECTORS - 1)) begin
            state_d = CHECK;
            vec_d   = 3'd0;
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end
      end
      CHECK: begin
        vec_d = 3'd0;
        if (abort) begin
          state_d     = IDLE;
          pass_d      = 1'b0;
          fail_mask_d = 8'd0;
        end else begin
          done_d      = 1'b1;
          pass_d      = (sig_q == EXPECTED);
          fail_mask_d = sig_q ^ EXPECTED;
          state_d     = start ? RUN : IDLE;
          clr_pend_d  = start;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    abc_d  = (state_d == RUN) ? vec_d : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 3'd0;
      abc_q       <= 3'd0;
      sig_q       <= 8'd0;
      pass_q      <= 1'b0;
      fail_mask_q <= 8'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      abc_q       <= abc_d;
      sig_q       <= sig_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  assign a         = abc_q[2];
  assign b         = abc_q[1];
  assign c         = abc_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign fail_mask = fail_mask_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gate3_bist_ctrl.sv
// Bench for gate3_bist_ctrl: two instances (H=4 XOR, H=1 AND) driven by
// behavioural gate models, with a done-triggered scoreboard.
module tb_gate3_bist_ctrl;
  import gate3_bist_pkg::*;

  localparam int         H0   = 4;
  localparam int         H1   = 1;
  localparam logic [7:0] EXP0 = TT_XOR3;
  localparam logic [7:0] EXP1 = TT_AND3;
  localparam int         W    = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic       abort [2];
  logic       f_in [2];
  logic       a [2];
  logic       b [2];
  logic       c [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [7:0] signature [2];
  logic [7:0] fail_mask [2];
  state_e     dbg [2];
  int         gsel [2];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // entry: {dut, done_cycle[31:0], signature[7:0], pass, fail_mask[7:0]}
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- gate models ----------------
  function automatic logic gate_f(input int g, input logic [2:0] v);
    case (g)
      0:       return ^v;
      1:       return &v;
      2:       return |v;
      3:       return ~&v;
      4:       return ~|v;
      5:       return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  // Expected signature: vector k is captured at edge (k+1)*h after start;
  // an abort sampled at edge abort_k stops any capture at or after that edge.
  function automatic logic [7:0] model_sig(input int g, input int h, input int abort_k);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 8; k++) begin
      if (abort_k == 0 || (k + 1) * h < abort_k) s[k] = gate_f(g, 3'(k));
    end
    return s;
  endfunction

  assign f_in[0] = gate_f(gsel[0], {a[0], b[0], c[0]});
  assign f_in[1] = gate_f(gsel[1], {a[1], b[1], c[1]});

  gate3_bist_ctrl #(.HOLD_CYCLES(H0), .EXPECTED(EXP0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .f_in(f_in[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(signature[0]), .fail_mask(fail_mask[0]), .dbg_state(dbg[0])
  );

  gate3_bist_ctrl #(.HOLD_CYCLES(H1), .EXPECTED(EXP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .f_in(f_in[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(signature[1]), .fail_mask(fail_mask[1]), .dbg_state(dbg[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done[0] === 1'b1 || done[1] === 1'b1)) begin
      int d;
      logic [W-1:0] e;
      d = (done[1] === 1'b1) ? 1 : 0;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: dut%0d got done=1 expected none (cycle %0d)", d, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_dut", 32'(d), 32'(e[49]));
        chk("done_cycle", 32'(cyc), e[48:17]);
        chk("done_signature", 32'(signature[d]), 32'(e[16:9]));
        chk("done_pass", 32'(pass[d]), 32'(e[8]));
        chk("done_fail_mask", 32'(fail_mask[d]), 32'(e[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input int d);
    chk("rst_abc", 32'({a[d], b[d], c[d]}), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_done", 32'(done[d]), 32'd0);
    chk("rst_pass", 32'(pass[d]), 32'd0);
    chk("rst_signature", 32'(signature[d]), 32'd0);
    chk("rst_fail_mask", 32'(fail_mask[d]), 32'd0);
    chk("rst_state", 32'(dbg[d]), 32'(IDLE));
  endtask

  // One test on dut d with gate g; abort_k > 0 asserts abort for edge E(abort_k).
  task automatic run_test(input int d, input int g, input int abort_k);
    int h, c0, steps;
    logic [7:0] expv, es;
    h    = (d == 0) ? H0 : H1;
    expv = (d == 0) ? EXP0 : EXP1;
    gsel[d] = g;
    es = model_sig(g, h, abort_k);
    @(negedge clk);
    c0 = cyc;
    start[d] = 1'b1;
    if (abort_k == 0) exp_q.push_back({1'(d), 32'(c0 + 8 * h + 2), es, es == expv, es ^ expv});
    steps = 8 * h + 1;
    for (int i = 1; i <= steps; i++) begin
      @(negedge clk);
      // stray start pulses while running must be ignored
      start[d] = (i <= 8 * h) && (abort_k == 0 || i < abort_k) && ($urandom_range(0, 3) == 0);
      abort[d] = (abort_k != 0) && (i == abort_k);
      if (i == 2 * h + 1 && (abort_k == 0 || i < abort_k))
        chk("vector_2", 32'({a[d], b[d], c[d]}), 32'd2);
    end
    @(negedge clk);
    start[d] = 1'b0;
    abort[d] = 1'b0;
    chk("busy_after", 32'(busy[d]), 32'd0);
    @(negedge clk);
    chk("done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("done_low", 32'(done[d]), 32'd0);
    chk("hold_signature", 32'(signature[d]), 32'(es));
    chk("hold_pass", 32'(pass[d]), (abort_k == 0) ? 32'(es == expv) : 32'd0);
    chk("hold_fail_mask", 32'(fail_mask[d]), (abort_k == 0) ? 32'(es ^ expv) : 32'd0);
  endtask

  // start held high across two tests on dut0
  task automatic back_to_back(input int g);
    int c0;
    logic [7:0] es;
    gsel[0] = g;
    es = model_sig(g, H0, 0);
    @(negedge clk);
    c0 = cyc;
    start[0] = 1'b1;
    exp_q.push_back({1'b0, 32'(c0 + 8 * H0 + 2), es, es == EXP0, es ^ EXP0});
    exp_q.push_back({1'b0, 32'(c0 + 16 * H0 + 3), es, es == EXP0, es ^ EXP0});
    for (int i = 1; i <= 16 * H0 + 2; i++) begin
      @(negedge clk);
      start[0] = (i <= 8 * H0 + 1);
      if (i == 8 * H0 + 2) chk("b2b_busy_between", 32'(busy[0]), 32'd1);
    end
    @(negedge clk);
    chk("b2b_busy_after", 32'(busy[0]), 32'd0);
    @(negedge clk);
    chk("b2b_done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    abort[0] = 1'b0; abort[1] = 1'b0;
    gsel[0]  = 0;    gsel[1]  = 1;
    repeat (2) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;

    run_test(0, 0, 0);          // XOR, H=4: pass
    run_test(0, 6, 0);          // f_in tied low: sig 00, fail_mask 96
    run_test(1, 1, 0);          // AND, H=1: pass
    run_test(0, 0, 11);         // abort sampled after vectors 0,1 captured
    run_test(0, 0, 8 * H0 + 1); // abort during CHECK

    for (int n = 0; n < 12; n++) begin
      int d, g, h, ak;
      d  = int'($urandom_range(0, 1));
      g  = int'($urandom_range(0, 6));
      h  = (d == 0) ? H0 : H1;
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8 * h + 1)) : 0;
      run_test(d, g, ak);
    end

    back_to_back(0);

    // asynchronous reset mid-test
    gsel[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    run_test(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
